// File: rtl/machine_top.sv
// Small 8-bit accumulator machine: 256x8 RAM, eight registers,
// FETCH/OPERAND/EXEC/HALT sequencer with ALU flags Z and C.

module machine_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] mem [0:255];

    assign rdata = mem[addr];

    // Synchronous write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

module machine_registers (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr,
    output logic [7:0] rdata,
    output logic [7:0] a_val
);
    logic [7:0] rega, regb, regc, regd;
    logic [7:0] rege, regf, regg, regt;

    assign a_val = rega;

    // Register file write port with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rega <= '0; regb <= '0; regc <= '0; regd <= '0;
            rege <= '0; regf <= '0; regg <= '0; regt <= '0;
        end else if (we) begin
            unique case (waddr)
                3'd0: rega <= wdata;
                3'd1: regb <= wdata;
                3'd2: regc <= wdata;
                3'd3: regd <= wdata;
                3'd4: rege <= wdata;
                3'd5: regf <= wdata;
                3'd6: regg <= wdata;
                3'd7: regt <= wdata;
            endcase
        end
    end

    // Single combinational read port selected by the instruction low bits.
    always_comb begin
        rdata = '0;
        unique case (raddr)
            3'd0: rdata = rega;
            3'd1: rdata = regb;
            3'd2: rdata = regc;
            3'd3: rdata = regd;
            3'd4: rdata = rege;
            3'd5: rdata = regf;
            3'd6: rdata = regg;
            3'd7: rdata = regt;
        endcase
    end
endmodule

module machine_cpu (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic       halted
);
    typedef enum logic [1:0] {FETCH, OPERAND, EXEC, HALT} state_t;

    state_t     state_q, state_d;
    logic [7:0] pc, pc_d;
    logic [7:0] ir, ir_d;
    logic [7:0] opnd, opnd_d;
    logic       z_flag, z_d;
    logic       c_flag, c_d;
    logic       halted_d;

    logic       reg_we;
    logic [2:0] reg_waddr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] a_val;

    logic [7:0] alu_res;
    logic       alu_c;
    logic [8:0] wide;

    logic is_hlt, is_mov, is_ldi, is_ld, is_st, is_jmp, is_alu;
    logic jmp_take;

    machine_registers m_registers (
        .clk   (clk),
        .reset (reset),
        .we    (reg_we),
        .waddr (reg_waddr),
        .wdata (reg_wdata),
        .raddr (ir[2:0]),
        .rdata (reg_rdata),
        .a_val (a_val)
    );

    // Jumps with ccc above 100 are undefined and therefore 1-byte NOPs.
    function automatic logic two_byte(input logic [7:0] op);
        return (op[7:3] == 5'b00010) || (op[7:3] == 5'b00011) ||
               (op[7:3] == 5'b00100) ||
               ((op[7:3] == 5'b00101) && (op[2:0] <= 3'd4));
    endfunction

    assign is_hlt = (ir == 8'h01);
    assign is_mov = (ir[7:6] == 2'b01);
    assign is_ldi = (ir[7:3] == 5'b00010);
    assign is_ld  = (ir[7:3] == 5'b00011);
    assign is_st  = (ir[7:3] == 5'b00100);
    assign is_jmp = (ir[7:3] == 5'b00101) && (ir[2:0] <= 3'd4);
    assign is_alu = (ir[7:6] == 2'b10);

    // Jump condition from the latched flags.
    always_comb begin
        jmp_take = 1'b0;
        unique case (ir[2:0])
            3'd0: jmp_take = 1'b1;
            3'd1: jmp_take = z_flag;
            3'd2: jmp_take = !z_flag;
            3'd3: jmp_take = c_flag;
            3'd4: jmp_take = !c_flag;
            default: jmp_take = 1'b0;
        endcase
    end

    // ALU: A op r, carry is carry-out for ADD and borrow for SUB/CMP.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        unique case (ir[5:3])
            3'd0: begin
                wide    = {1'b0, a_val} + {1'b0, reg_rdata};
                alu_res = wide[7:0];
                alu_c   = wide[8];
            end
            3'd1, 3'd7: begin
                wide    = {1'b0, a_val} - {1'b0, reg_rdata};
                alu_res = wide[7:0];
                alu_c   = wide[8];
            end
            3'd2: alu_res = a_val & reg_rdata;
            3'd3: alu_res = a_val | reg_rdata;
            3'd4: alu_res = a_val ^ reg_rdata;
            3'd5: begin
                alu_res = {a_val[6:0], 1'b0};
                alu_c   = a_val[7];
            end
            3'd6: begin
                alu_res = {1'b0, a_val[7:1]};
                alu_c   = a_val[0];
            end
        endcase
    end

    // Sequencer next-state, datapath control and memory port steering.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc;
        ir_d      = ir;
        opnd_d    = opnd;
        z_d       = z_flag;
        c_d       = c_flag;
        halted_d  = halted;
        mem_addr  = pc;
        mem_we    = 1'b0;
        mem_wdata = reg_rdata;
        reg_we    = 1'b0;
        reg_waddr = ir[2:0];
        reg_wdata = opnd;
        unique case (state_q)
            FETCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc + 8'd1;
                state_d = two_byte(mem_rdata) ? OPERAND : EXEC;
            end
            OPERAND: begin
                opnd_d  = mem_rdata;
                pc_d    = pc + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                unique case (1'b1)
                    is_hlt: begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                    is_mov: begin
                        reg_we    = 1'b1;
                        reg_waddr = ir[5:3];
                        reg_wdata = reg_rdata;
                    end
                    is_ldi: reg_we = 1'b1;
                    is_ld: begin
                        mem_addr  = opnd;
                        reg_we    = 1'b1;
                        reg_wdata = mem_rdata;
                    end
                    is_st: begin
                        mem_addr = opnd;
                        mem_we   = 1'b1;
                    end
                    is_jmp: begin
                        if (jmp_take) pc_d = opnd;
                    end
                    is_alu: begin
                        z_d = (alu_res == 8'h00);
                        c_d = alu_c;
                        if (ir[5:3] != 3'd7) begin
                            reg_we    = 1'b1;
                            reg_waddr = 3'd0;
                            reg_wdata = alu_res;
                        end
                    end
                    default: ;
                endcase
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Architectural state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc      <= '0;
            ir      <= '0;
            opnd    <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            ir      <= ir_d;
            opnd    <= opnd_d;
            z_flag  <= z_d;
            c_flag  <= c_d;
            halted  <= halted_d;
        end
    end
endmodule

module machine_top (
    input  logic clk,
    input  logic reset,
    output logic halted
);
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_we;

    machine_ram m_ram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    machine_cpu m_cpu (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .halted    (halted)
    );
endmodule

// File: tb/tb_machine_top.sv
// Directed program vectors for machine_top: final register/flag state,
// halt latency, HALT stickiness and reset in the middle of a run.

module tb_machine_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic halted;

    int tests = 0;
    int fails = 0;

    machine_top dut (
        .clk    (clk),
        .reset  (reset),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] prog;
        int           len;
        logic [7:0]   a, b, c, d;
        logic         z, cf;
        int           cyc;
        logic         chk_mem;
        logic [7:0]   maddr, mval;
    } vec_t;

    vec_t tv [8];
    int   nvec = 0;

    task automatic add(input logic [127:0] p, input int n,
                       input logic [7:0] a, b, c, d,
                       input logic z, cf, input int cyc,
                       input logic cm, input logic [7:0] ma, mv);
        tv[nvec].prog = p;   tv[nvec].len = n;
        tv[nvec].a = a;      tv[nvec].b = b;
        tv[nvec].c = c;      tv[nvec].d = d;
        tv[nvec].z = z;      tv[nvec].cf = cf;
        tv[nvec].cyc = cyc;  tv[nvec].chk_mem = cm;
        tv[nvec].maddr = ma; tv[nvec].mval = mv;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Hold reset, clear RAM, load program bytes, then release reset.
    task automatic load_and_reset(input int idx);
        reset = 1'b1;
        for (int k = 0; k < 256; k++) dut.m_ram.mem[k] = 8'h00;
        for (int k = 0; k < tv[idx].len; k++)
            dut.m_ram.mem[k] = tv[idx].prog[8*(tv[idx].len-1-k) +: 8];
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_final(input int idx, input int cyc,
                               input string tag);
        chk({tag, " halted"}, {31'd0, halted}, 32'd1);
        chk({tag, " cycles"}, cyc, tv[idx].cyc);
        chk({tag, " A"}, {24'd0, dut.m_cpu.m_registers.rega}, {24'd0, tv[idx].a});
        chk({tag, " B"}, {24'd0, dut.m_cpu.m_registers.regb}, {24'd0, tv[idx].b});
        chk({tag, " C"}, {24'd0, dut.m_cpu.m_registers.regc}, {24'd0, tv[idx].c});
        chk({tag, " D"}, {24'd0, dut.m_cpu.m_registers.regd}, {24'd0, tv[idx].d});
        chk({tag, " Z"}, {31'd0, dut.m_cpu.z_flag}, {31'd0, tv[idx].z});
        chk({tag, " Cf"}, {31'd0, dut.m_cpu.c_flag}, {31'd0, tv[idx].cf});
        if (tv[idx].chk_mem)
            chk({tag, " mem"}, {24'd0, dut.m_ram.mem[tv[idx].maddr]},
                {24'd0, tv[idx].mval});
    endtask

    initial begin
        int cyc;
        logic [7:0] pc_hold;
        logic [7:0] a_hold;
        // 0: LDI A,5; LDI B,3; ADD B; HLT
        add({8'h10,8'h05,8'h11,8'h03,8'h81,8'h01}, 6,
            8'h08, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 10, 1'b0, 8'h00, 8'h00);
        // 1: 2-3 borrows
        add({8'h10,8'h02,8'h11,8'h03,8'h89,8'h01}, 6,
            8'hFF, 8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 10, 1'b0, 8'h00, 8'h00);
        // 2: LDI C,AA; ST [80],C; LD D,[80]; HLT
        add({8'h12,8'hAA,8'h22,8'h80,8'h1B,8'h80,8'h01}, 7,
            8'h00, 8'h00, 8'hAA, 8'hAA, 1'b0, 1'b0, 11, 1'b1, 8'h80, 8'hAA);
        // 3: countdown loop with JNZ, three passes
        add({8'h10,8'h03,8'h11,8'h01,8'h89,8'h2A,8'h04,8'h01}, 8,
            8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 23, 1'b0, 8'h00, 8'h00);
        // 4: LDI A,7F; MOV B,A; SUB B; HLT
        add({8'h10,8'h7F,8'h48,8'h89,8'h01}, 5,
            8'h00, 8'h7F, 8'h00, 8'h00, 1'b1, 1'b0, 9, 1'b0, 8'h00, 8'h00);
        // 5: SHL (C=A7), LDI B, OR B (C=0), SHR (C=A0)
        add({8'h10,8'h81,8'hA8,8'h11,8'h0F,8'h99,8'hB0,8'h01}, 8,
            8'h07, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1, 14, 1'b0, 8'h00, 8'h00);
        // 6: CMP A, JZ taken, SUB A, JC not taken, ccc=101 NOP, AND B
        add({8'h10,8'h05,8'hB8,8'h29,8'h08,8'h10,8'hFF,8'h01,
             8'h88,8'h2B,8'h0E,8'h2D,8'h91,8'h01}, 14,
            8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 19, 1'b0, 8'h00, 8'h00);
        // 7: ADD carry-out, MOV C,A, LDI T, MOV D,T
        add({8'h10,8'hF0,8'h11,8'h20,8'h81,8'h50,8'h17,8'h5A,8'h5F,8'h01}, 10,
            8'h10, 8'h20, 8'h10, 8'h5A, 1'b0, 1'b1, 17, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < nvec; i++) begin
            load_and_reset(i);
            run_to_halt(cyc);
            check_final(i, cyc, $sformatf("prog%0d", i));
        end

        // HALT is sticky: nothing moves for several cycles.
        pc_hold = dut.m_cpu.pc;
        a_hold  = dut.m_cpu.m_registers.rega;
        repeat (6) @(posedge clk);
        #1;
        chk("halt sticky", {31'd0, halted}, 32'd1);
        chk("halt pc", {24'd0, dut.m_cpu.pc}, {24'd0, pc_hold});
        chk("halt A", {24'd0, dut.m_cpu.m_registers.rega}, {24'd0, a_hold});

        // Reset in the middle of the countdown loop.
        load_and_reset(3);
        repeat (12) @(posedge clk);
        #1;
        chk("midrun not halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst regs", {dut.m_cpu.m_registers.rega, dut.m_cpu.m_registers.regb,
                         dut.m_cpu.m_registers.regc, dut.m_cpu.m_registers.regd},
            32'd0);
        chk("rst regs2", {dut.m_cpu.m_registers.rege, dut.m_cpu.m_registers.regf,
                          dut.m_cpu.m_registers.regg, dut.m_cpu.m_registers.regt},
            32'd0);
        chk("rst pc", {24'd0, dut.m_cpu.pc}, 32'd0);
        chk("rst flags", {29'd0, halted, dut.m_cpu.z_flag, dut.m_cpu.c_flag},
            32'd0);
        reset = 1'b0;
        run_to_halt(cyc);
        check_final(3, cyc, "rerun");

        // Reset also clears a halted machine.
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst from halt", {31'd0, halted}, 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
